// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/compare ops, iterative shift-add MUL and
// restoring DIV/MOD behind valid/ready handshakes on both the request and result side.
module alu_seq #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_ctl,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_res,
    output logic             o_dbz,
    output logic             o_busy
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;
    localparam logic [3:0] ALU_SLL = 4'h5;
    localparam logic [3:0] ALU_SRL = 4'h6;
    localparam logic [3:0] ALU_SRA = 4'h7;
    localparam logic [3:0] ALU_SLA = 4'h8;
    localparam logic [3:0] ALU_SIE = 4'h9;
    localparam logic [3:0] ALU_SIL = 4'hA;
    localparam logic [3:0] ALU_MUL = 4'hB;
    localparam logic [3:0] ALU_DIV = 4'hC;
    localparam logic [3:0] ALU_MOD = 4'hD;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t r_state, w_next;

    logic [WIDTH-1:0]        r_a, r_b, r_acc, r_res;
    logic [SW-1:0]           r_cnt;
    logic                    r_dbz, r_is_mul, r_is_mod;

    logic                    w_accept, w_iter_op;
    logic [SW-1:0]           w_shamt;
    logic signed [WIDTH-1:0] w_op1_s;
    logic [WIDTH-1:0]        w_res1;
    logic [WIDTH-1:0]        w_mul_acc, w_diff, w_rem_nx, w_quo_nx;
    logic [WIDTH:0]          w_trial;
    logic                    w_ge;

    assign w_accept  = i_valid & o_ready;
    assign w_iter_op = (i_ctl == ALU_DIV) || (i_ctl == ALU_MOD) ||
                       ((i_ctl == ALU_MUL) && !FAST_MUL);
    assign w_shamt   = i_op2[SW-1:0];
    assign w_op1_s   = i_op1;

    always_comb begin
        w_res1 = '0;
        case (i_ctl)
            ALU_ADD:          w_res1 = i_op1 + i_op2;
            ALU_SUB:          w_res1 = i_op1 - i_op2;
            ALU_AND:          w_res1 = i_op1 & i_op2;
            ALU_OR:           w_res1 = i_op1 | i_op2;
            ALU_XOR:          w_res1 = i_op1 ^ i_op2;
            ALU_SLL, ALU_SLA: w_res1 = i_op1 << w_shamt;
            ALU_SRL:          w_res1 = i_op1 >> w_shamt;
            ALU_SRA:          w_res1 = w_op1_s >>> w_shamt;
            ALU_SIE:          w_res1 = WIDTH'(i_op1 == i_op2);
            ALU_SIL:          w_res1 = WIDTH'(i_op1 < i_op2);
            ALU_MUL:          w_res1 = FAST_MUL ? i_op1 * i_op2 : '0;
            default:          w_res1 = '0;
        endcase
    end

    // One iteration step. MUL: r_a multiplicand, r_b multiplier, r_acc partial product.
    // DIV/MOD: r_a divisor, r_b dividend shifting into quotient, r_acc remainder.
    // A zero divisor always "fits", which yields an all-ones quotient and remainder == op1.
    assign w_mul_acc = r_acc + (r_b[0] ? r_a : '0);
    assign w_trial   = {r_acc, r_b[WIDTH-1]};
    assign w_ge      = w_trial >= {1'b0, r_a};
    assign w_diff    = w_trial[WIDTH-1:0] - r_a;
    assign w_rem_nx  = w_ge ? w_diff : w_trial[WIDTH-1:0];
    assign w_quo_nx  = {r_b[WIDTH-2:0], w_ge};

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_busy  = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) w_next = w_iter_op ? S_BUSY : S_DONE;
            end
            S_BUSY: begin
                o_busy = 1'b1;
                if (r_cnt == LAST) w_next = S_DONE;
            end
            S_DONE: begin
                o_valid = 1'b1;
                o_ready = i_ready;
                if (i_ready) begin
                    if (i_valid) w_next = w_iter_op ? S_BUSY : S_DONE;
                    else         w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_res <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_is_mul <= (i_ctl == ALU_MUL);
            r_is_mod <= (i_ctl == ALU_MOD);
            r_acc    <= '0;
            r_a      <= (i_ctl == ALU_MUL) ? i_op1 : i_op2;
            r_b      <= (i_ctl == ALU_MUL) ? i_op2 : i_op1;
            if (w_iter_op) begin
                r_dbz <= (i_ctl != ALU_MUL) && (i_op2 == '0);
            end else begin
                r_res <= w_res1;
                r_dbz <= 1'b0;
            end
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + SW'(1);
            if (r_is_mul) begin
                r_acc <= w_mul_acc;
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
            end else begin
                r_acc <= w_rem_nx;
                r_b   <= w_quo_nx;
            end
            if (r_cnt == LAST)
                r_res <= r_is_mul ? w_mul_acc : (r_is_mod ? w_rem_nx : w_quo_nx);
        end
    end

    assign o_res = r_res;
    assign o_dbz = r_dbz;
endmodule
